// File: rtl/emu_io_link.sv
// rtl/emu_io_link.sv - byte-stream command controller for the board-I/O emulator
// Host opcodes drive the packed DUT inputs and return a coherent outputs snapshot.
module emu_io_link #(
    parameter int IN_W   = 14,
    parameter int OUT_W  = 52,
    parameter int SETTLE = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [IN_W-1:0]  inputs_state,
    input  logic [OUT_W-1:0] outputs_state,
    output logic             busy
);

    localparam int IN_B  = (IN_W + 7) / 8;
    localparam int OUT_B = (OUT_W + 7) / 8;
    localparam int AW    = $clog2(IN_B + 1);
    localparam int DW    = $clog2(OUT_B + 1);
    localparam int CW    = $clog2(SETTLE + 1);

    localparam logic [AW-1:0] ARG_LAST  = AW'(IN_B - 1);
    localparam logic [DW-1:0] DATA_LAST = DW'(OUT_B - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_ARG,
        S_SETTLE,
        S_SNAP,
        S_TX_HDR,
        S_TX_DATA,
        S_TX_ERR
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [8*IN_B-1:0]      r_shadow;
    logic [8*IN_B-1:0]      w_shadow_next;
    logic [AW-1:0]          r_arg_idx;
    logic [IN_W-1:0]        r_in;
    logic [CW-1:0]          r_cnt;
    logic [8*OUT_B-1:0]     r_snap;
    logic [DW-1:0]          r_tx_idx;
    logic                   w_rx_fire;
    logic                   w_tx_fire;

    assign w_rx_fire    = rx_valid & rx_ready;
    assign w_tx_fire    = tx_valid & tx_ready;
    assign inputs_state = r_in;

    always_comb begin
        w_shadow_next = r_shadow;
        w_shadow_next[r_arg_idx*8 +: 8] = rx_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (w_rx_fire) begin
                    if (rx_data == 8'h01)      w_next = S_RX_ARG;
                    else if (rx_data == 8'h02) w_next = S_SNAP;
                    else                       w_next = S_TX_ERR;
                end
            end
            S_RX_ARG: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_rx_fire && r_arg_idx == ARG_LAST) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (r_cnt == '0) w_next = S_SNAP;
            end
            S_SNAP: begin
                busy   = 1'b1;
                w_next = S_TX_HDR;
            end
            S_TX_HDR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = 8'hA5;
                if (w_tx_fire) w_next = S_TX_DATA;
            end
            S_TX_DATA: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = r_snap[r_tx_idx*8 +: 8];
                if (w_tx_fire && r_tx_idx == DATA_LAST) w_next = S_IDLE;
            end
            S_TX_ERR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = 8'hEE;
                if (w_tx_fire) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Handshake outputs are masked while reset is held, before the state settles.
        if (RST) begin
            rx_ready = 1'b0;
            tx_valid = 1'b0;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shadow  <= '0;
            r_arg_idx <= '0;
            r_in      <= '0;
            r_cnt     <= '0;
            r_snap    <= '0;
            r_tx_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_arg_idx <= '0;
                S_RX_ARG: begin
                    if (w_rx_fire) begin
                        r_shadow  <= w_shadow_next;
                        r_arg_idx <= r_arg_idx + 1'b1;
                        // Whole word lands at once so the DUT never sees a partial value.
                        if (r_arg_idx == ARG_LAST) begin
                            r_in  <= w_shadow_next[IN_W-1:0];
                            r_cnt <= CW'(SETTLE - 1);
                        end
                    end
                end
                S_SETTLE: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                S_SNAP:    r_snap   <= (8*OUT_B)'(outputs_state);
                S_TX_HDR:  r_tx_idx <= '0;
                S_TX_DATA: if (w_tx_fire) r_tx_idx <= r_tx_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_emu_io_link.sv
// tb/tb_emu_io_link.sv - scoreboard bench for emu_io_link
module tb_emu_io_link;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [13:0] inputs_state;
    logic [51:0] outputs_state;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_tx_seen = 0;
    logic [8:0]  exp_q[$];

    emu_io_link #(.IN_W(14), .OUT_W(52), .SETTLE(2)) dut (
        .CLK(CLK), .RST(RST),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .inputs_state(inputs_state), .outputs_state(outputs_state), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_snap(input logic [51:0] v);
        logic [55:0] z;
        z = {4'h0, v};
        exp_q.push_back(9'h0A5);
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, z[i*8 +: 8]});
    endtask

    // Every accepted response byte is matched against the scoreboard head.
    always @(negedge CLK) begin
        if (!RST && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check_eq("tx_unexpected", {56'h0, tx_data}, 64'h100);
            else check_eq("tx_byte", {56'h0, tx_data}, {55'h0, exp_q.pop_front()});
            n_tx_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!done) begin
            @(negedge CLK);
            if (rx_ready) done = 1;
            else begin
                n++;
                if (n > 100) begin
                    check_eq("rx_timeout", 64'h0, 64'h1);
                    done = 1;
                end
            end
        end
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(exp_q.size() == 0 && !busy) && n < 300);
        if (n >= 300) check_eq("drain_timeout", 64'h0, 64'h1);
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (cycles) begin
            @(negedge CLK);
            check_eq("rst_rx_ready", {63'h0, rx_ready}, 64'h0);
            check_eq("rst_busy", {63'h0, busy}, 64'h0);
            check_eq("rst_tx_valid", {63'h0, tx_valid}, 64'h0);
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
    endtask

    initial begin
        logic [7:0]  held;
        logic [51:0] v;
        int          lat;

        RST = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        outputs_state = '0;

        // Reset
        pulse_reset(3);
        check_eq("rst_inputs_state", {50'h0, inputs_state}, 64'h0);
        @(negedge CLK);
        check_eq("post_rst_rx_ready", {63'h0, rx_ready}, 64'h1);
        check_eq("post_rst_busy", {63'h0, busy}, 64'h0);
        @(posedge CLK);
        #1;

        // SET with header latency
        tx_ready = 1'b1;
        outputs_state = 52'h0ABC;
        push_snap(52'h0ABC);
        send_byte(8'h01);
        send_byte(8'h34);
        send_byte(8'h12);
        check_eq("set_inputs_state", {50'h0, inputs_state}, 64'h1234);
        lat = 0;
        while (!tx_valid && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check_eq("set_hdr_latency", 64'(lat), 64'd3);
        wait_idle();

        // Width clip and all-ones snapshot
        outputs_state = '1;
        push_snap('1);
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'hFF);
        check_eq("clip_inputs_state", {50'h0, inputs_state}, 64'h3FFF);
        wait_idle();
        push_snap('1);
        send_byte(8'h02);
        wait_idle();
        check_eq("read_keeps_inputs", {50'h0, inputs_state}, 64'h3FFF);

        // Backpressure and snapshot coherence
        v = 52'h9_8765_4321_0FED;
        outputs_state = v;
        push_snap(v);
        n_tx_seen = 0;
        send_byte(8'h02);
        lat = 0;
        while (n_tx_seen < 2 && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        check_eq("bp_reach_byte2", 64'(n_tx_seen), 64'd2);
        @(posedge CLK);
        #1;
        tx_ready = 1'b0;
        held = tx_data;
        repeat (5) begin
            outputs_state = {$urandom, $urandom} & 52'hF_FFFF_FFFF_FFFF;
            @(negedge CLK);
            check_eq("bp_tx_hold", {56'h0, tx_data}, {56'h0, held});
            check_eq("bp_tx_valid", {63'h0, tx_valid}, 64'h1);
            @(posedge CLK);
            #1;
        end
        tx_ready = 1'b1;
        wait_idle();

        // Bad opcode
        exp_q.push_back(9'h0EE);
        send_byte(8'h7F);
        wait_idle();
        check_eq("err_inputs_state", {50'h0, inputs_state}, 64'h3FFF);
        check_eq("err_idle", {63'h0, busy}, 64'h0);

        // Reset in the middle of argument reception
        send_byte(8'h01);
        send_byte(8'h55);
        pulse_reset(1);
        check_eq("midrst_inputs_state", {50'h0, inputs_state}, 64'h0);
        v = 52'h0_0000_00C0_FFEE;
        outputs_state = v;
        push_snap(v);
        send_byte(8'h02);
        wait_idle();
        check_eq("midrst_inputs_after", {50'h0, inputs_state}, 64'h0);
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
